// File: rtl/pdm_mic_cic.sv
// ---------------------------------------------------------------------------
// pdm_mic_cic
//
// Stereo PDM microphone front end: generates the microphone bit clock,
// captures two interleaved PDM channels from asynchronous pins, and decimates
// each channel with a 3rd-order CIC filter (differential delay 1) to signed
// PCM samples.
//
// Parameters
//   C_MIC_CK_DIV  CK_i cycles per MIC_CK_o period (even, >= 4)
//   C_DECIM_LOG2  log2 of the decimation ratio R (in MIC_CK_o periods)
//   C_OUT_W       PCM sample width, signed two's complement
//
// Ports
//   CK_i        in   system clock, the only clock in the block
//   RST_i       in   synchronous, active-high reset
//   MIC_CK_o    out  PDM bit clock to the microphones (registered)
//   MICs_DAT_i  in   raw PDM pins, asynchronous; [0] = ch0, [1] = ch1
//   PCMs_o      out  decimated samples; low half = ch0, high half = ch1
//   PCM_EE_o    out  one-cycle strobe marking a new PCMs_o value
//   SATs_o      out  per-channel clip flag belonging to the current PCMs_o
// ---------------------------------------------------------------------------
module pdm_mic_cic #(
  parameter int C_MIC_CK_DIV = 16,
  parameter int C_DECIM_LOG2 = 6,
  parameter int C_OUT_W      = 16
) (
  input  logic                   CK_i,
  input  logic                   RST_i,
  output logic                   MIC_CK_o,
  input  logic [1:0]             MICs_DAT_i,
  output logic [2*C_OUT_W-1:0]   PCMs_o,
  output logic                   PCM_EE_o,
  output logic [1:0]             SATs_o
);

  // Accumulator width: 3 stages of R-fold growth plus sign and one guard bit.
  localparam int W     = 3 * C_DECIM_LOG2 + 2;
  localparam int PH_W  = $clog2(C_MIC_CK_DIV);
  localparam int SHIFT = W - C_OUT_W - 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(C_MIC_CK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(C_MIC_CK_DIV / 2);
  localparam logic [PH_W-1:0] PH_CH1  = PH_W'(C_MIC_CK_DIV / 2 - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  localparam logic [C_DECIM_LOG2-1:0] DEC_ONE = C_DECIM_LOG2'(1);

  localparam int OUT_MAX_I = (1 << (C_OUT_W - 1)) - 1;
  localparam int OUT_MIN_I = -OUT_MAX_I - 1;
  localparam logic signed [W-1:0] OUT_MAX = W'(OUT_MAX_I);
  localparam logic signed [W-1:0] OUT_MIN = W'(OUT_MIN_I);

  localparam logic signed [W-1:0] PLUS_ONE  = W'(1);
  localparam logic signed [W-1:0] MINUS_ONE = '1;

  // -------------------------------------------------------------------------
  // Phase / decimation timing
  // -------------------------------------------------------------------------
  logic [PH_W-1:0]         ph;
  logic [PH_W-1:0]         ph_next;
  logic [C_DECIM_LOG2-1:0] dec;
  logic                    tick;

  always_comb begin
    ph_next = (ph == PH_LAST) ? '0 : ph + PH_ONE;
  end

  // The tick is the last cycle of the last bit-clock period of a frame; the
  // ch0 sample taken in that same cycle still belongs to the frame.
  assign tick = (ph == PH_LAST) && (&dec);

  // MIC_CK_o is derived from the next phase so that the registered pin is
  // high exactly while ph sits in the upper half of the period.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      ph       <= '0;
      dec      <= '0;
      MIC_CK_o <= 1'b0;
    end else begin
      ph       <= ph_next;
      MIC_CK_o <= (ph_next >= PH_HALF);
      if (ph == PH_LAST) begin
        dec <= dec + DEC_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Two-flop synchronizer on the asynchronous data pins
  // -------------------------------------------------------------------------
  logic [1:0] sync_a;
  logic [1:0] sync_b;

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= MICs_DAT_i;
      sync_b <= sync_a;
    end
  end

  // -------------------------------------------------------------------------
  // Integrator cascades, one per channel
  // -------------------------------------------------------------------------
  logic signed [W-1:0] integ1 [2];
  logic signed [W-1:0] integ2 [2];
  logic signed [W-1:0] integ3 [2];
  logic signed [W-1:0] step   [2];
  logic signed [W-1:0] i1_nx  [2];
  logic signed [W-1:0] i2_nx  [2];
  logic signed [W-1:0] i3_nx  [2];
  logic [1:0]          sample_en;

  // ch1 drives its bit while MIC_CK is low and ch0 while it is high, so each
  // channel is captured at the end of the half period it owns. The cascade
  // feeds each stage the freshly updated value of the previous one, giving a
  // pure 1/(1-z^-1)^3 response; all sums wrap modulo 2^W.
  always_comb begin
    sample_en[0] = (ph == PH_LAST);
    sample_en[1] = (ph == PH_CH1);
    for (int n = 0; n < 2; n++) begin
      step[n]  = sync_b[n] ? PLUS_ONE : MINUS_ONE;
      i1_nx[n] = integ1[n] + step[n];
      i2_nx[n] = integ2[n] + i1_nx[n];
      i3_nx[n] = integ3[n] + i2_nx[n];
    end
  end

  // Each channel's integrators advance only in that channel's sample cycle.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      for (int n = 0; n < 2; n++) begin
        integ1[n] <= '0;
        integ2[n] <= '0;
        integ3[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (sample_en[n]) begin
          integ1[n] <= i1_nx[n];
          integ2[n] <= i2_nx[n];
          integ3[n] <= i3_nx[n];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Comb pipeline and output scaling
  // -------------------------------------------------------------------------
  logic                v1;
  logic                v2;
  logic                v3;
  logic signed [W-1:0] comb1 [2];
  logic signed [W-1:0] comb2 [2];
  logic signed [W-1:0] comb3 [2];
  logic signed [W-1:0] dly1  [2];
  logic signed [W-1:0] dly2  [2];
  logic signed [W-1:0] dly3  [2];
  logic [C_OUT_W-1:0]  pcm_nx [2];
  logic [1:0]          sat_nx;

  // Arithmetic shift down to the output width, then clamp; the top bit of
  // the result is the clip flag.
  function automatic logic [C_OUT_W:0] scale_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] s;
    s = v >>> SHIFT;
    if (s > OUT_MAX) begin
      scale_sat = {1'b1, OUT_MAX[C_OUT_W-1:0]};
    end else if (s < OUT_MIN) begin
      scale_sat = {1'b1, OUT_MIN[C_OUT_W-1:0]};
    end else begin
      scale_sat = {1'b0, s[C_OUT_W-1:0]};
    end
  endfunction

  // The third comb difference is resolved in the same cycle it is scaled, so
  // the output registers are loaded directly from it.
  always_comb begin
    sat_nx = '0;
    for (int n = 0; n < 2; n++) begin
      comb3[n] = comb2[n] - dly3[n];
      {sat_nx[n], pcm_nx[n]} = scale_sat(comb3[n]);
    end
  end

  // v1..v3 walk the tick down the pipeline. The integrators are read in the
  // cycle after the tick (their snapshot becomes the first comb delay), and
  // each following cycle completes one more comb stage. Clearing the valids
  // on reset drops any frame that is still in flight.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      PCM_EE_o <= 1'b0;
      PCMs_o   <= '0;
      SATs_o   <= '0;
      for (int n = 0; n < 2; n++) begin
        comb1[n] <= '0;
        comb2[n] <= '0;
        dly1[n]  <= '0;
        dly2[n]  <= '0;
        dly3[n]  <= '0;
      end
    end else begin
      v1       <= tick;
      v2       <= v1;
      v3       <= v2;
      PCM_EE_o <= v3;
      for (int n = 0; n < 2; n++) begin
        if (v1) begin
          comb1[n] <= integ3[n] - dly1[n];
          dly1[n]  <= integ3[n];
        end
        if (v2) begin
          comb2[n] <= comb1[n] - dly2[n];
          dly2[n]  <= comb1[n];
        end
        if (v3) begin
          dly3[n]                          <= comb2[n];
          PCMs_o[n*C_OUT_W +: C_OUT_W]     <= pcm_nx[n];
        end
      end
      if (v3) begin
        SATs_o <= sat_nx;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_cic.sv
// ---------------------------------------------------------------------------
// tb_pdm_mic_cic
//
// Drives pdm_mic_cic with constant, alternating and random PDM streams and
// compares clock, strobe timing and PCM words against a reference that
// computes each output directly as the CIC impulse response (three cascaded
// length-R boxcars) convolved with the +/-1 sample history of each channel.
// ---------------------------------------------------------------------------
module tb_pdm_mic_cic;

  localparam int DIV      = 16;
  localparam int R        = 64;
  localparam int FRAME    = DIV * R;
  localparam int FIRST_EE = FRAME - 1 + 4;
  localparam int NTAP     = 3 * R - 2;
  localparam int MAXP     = 4096;

  logic        CK_i = 1'b0;
  logic        RST_i;
  logic        MIC_CK_o;
  logic [1:0]  MICs_DAT_i;
  logic [31:0] PCMs_o;
  logic        PCM_EE_o;
  logic [1:0]  SATs_o;

  int checks = 0;
  int errors = 0;

  int h [NTAP];
  bit s0 [MAXP];
  bit s1 [MAXP];

  pdm_mic_cic #(
    .C_MIC_CK_DIV (DIV),
    .C_DECIM_LOG2 (6),
    .C_OUT_W      (16)
  ) dut (
    .CK_i       (CK_i),
    .RST_i      (RST_i),
    .MIC_CK_o   (MIC_CK_o),
    .MICs_DAT_i (MICs_DAT_i),
    .PCMs_o     (PCMs_o),
    .PCM_EE_o   (PCM_EE_o),
    .SATs_o     (SATs_o)
  );

  always #10 CK_i = ~CK_i;

  // One comparison: counted, and reported with tag and both values on a miss.
  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Output of channel ch for frame k: FIR with the CIC impulse response over
  // that channel's samples, zero history before reset, then >>3 and clamp.
  task automatic modelFrame(input int ch, input int k, output int pcm, output bit sat);
    int acc;
    int nk;
    int scaled;
    acc = 0;
    nk  = k * R + R - 1;
    for (int j = 0; j < NTAP; j++) begin
      if (nk - j >= 0) begin
        acc += h[j] * (((ch == 0) ? s0[nk - j] : s1[nk - j]) ? 1 : -1);
      end
    end
    scaled = acc >>> 3;
    if (scaled > 32767) begin
      pcm = 32767;  sat = 1'b1;
    end else if (scaled < -32768) begin
      pcm = -32768; sat = 1'b1;
    end else begin
      pcm = scaled; sat = 1'b0;
    end
  endtask

  task automatic doReset();
    RST_i = 1'b1;
    repeat (3) @(posedge CK_i);
    #1;
    RST_i = 1'b0;
  endtask

  // Runs ncycles cycles starting at the first cycle after reset release.
  // mode 0: both 1; mode 1: both 0; mode 2: ch0 alternates 1,0.. ch1 = 1;
  // mode 3: random bits, each pin valid only in the cycle that reaches its
  // sample point through the synchronizer and inverted at all other times.
  task automatic applyStimulus(input int mode, input int ncycles);
    int ph;
    int p;
    int k;
    int dens0;
    int dens1;
    int exp_pcm0;
    int exp_pcm1;
    bit exp_sat0;
    bit exp_sat1;
    int last_ee;
    bit exp_ee;
    dens0 = 50; dens1 = 50;
    last_ee = -1;
    exp_pcm0 = 0; exp_pcm1 = 0; exp_sat0 = 1'b0; exp_sat1 = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      ph = c % DIV;
      p  = c / DIV;
      if (ph == 0) begin
        if (mode == 3 && p % R == 0) begin
          dens0 = $urandom_range(3, 97);
          dens1 = $urandom_range(3, 97);
        end
        case (mode)
          0:       begin s0[p] = 1'b1; s1[p] = 1'b1; end
          1:       begin s0[p] = 1'b0; s1[p] = 1'b0; end
          2:       begin s0[p] = (p % 2 == 0); s1[p] = 1'b1; end
          default: begin
            s0[p] = ($urandom_range(0, 99) < dens0);
            s1[p] = ($urandom_range(0, 99) < dens1);
          end
        endcase
      end
      if (mode == 3) begin
        MICs_DAT_i[1] = (ph == 5)  ? s1[p] : ~s1[p];
        MICs_DAT_i[0] = (ph == 13) ? s0[p] : ~s0[p];
      end else begin
        MICs_DAT_i = {s1[p], s0[p]};
      end

      checkOutput("mic_ck", 64'(MIC_CK_o), 64'(ph >= DIV / 2));
      exp_ee = (c >= FIRST_EE) && ((c - FIRST_EE) % FRAME == 0);
      checkOutput("pcm_ee", 64'(PCM_EE_o), 64'(exp_ee));

      if (c < 5) begin
        checkOutput("pcm_rst", 64'(PCMs_o), 64'd0);
        checkOutput("sat_rst", 64'(SATs_o), 64'd0);
      end

      if (exp_ee) begin
        k = (c - FIRST_EE) / FRAME;
        last_ee = c;
        if (k >= 3) begin
          modelFrame(0, k, exp_pcm0, exp_sat0);
          modelFrame(1, k, exp_pcm1, exp_sat1);
          checkOutput("pcm_ch0", 64'($signed(PCMs_o[15:0])), 64'(exp_pcm0));
          checkOutput("pcm_ch1", 64'($signed(PCMs_o[31:16])), 64'(exp_pcm1));
          checkOutput("sat_ch0", 64'(SATs_o[0]), 64'(exp_sat0));
          checkOutput("sat_ch1", 64'(SATs_o[1]), 64'(exp_sat1));
        end
      end

      if (last_ee >= FIRST_EE + 3 * FRAME && c == last_ee + FRAME / 2) begin
        checkOutput("hold_ch0", 64'($signed(PCMs_o[15:0])), 64'(exp_pcm0));
        checkOutput("hold_ch1", 64'($signed(PCMs_o[31:16])), 64'(exp_pcm1));
        checkOutput("hold_sat", 64'(SATs_o), 64'({exp_sat1, exp_sat0}));
      end

      @(posedge CK_i);
      #1;
    end
  endtask

  initial begin
    int b2 [2*R-1];
    RST_i      = 1'b1;
    MICs_DAT_i = 2'b00;

    // CIC impulse response: boxcar * boxcar * boxcar, each of length R.
    for (int i = 0; i < 2*R-1; i++) b2[i] = 0;
    for (int i = 0; i < NTAP; i++) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) b2[i+j] += 1;
    for (int i = 0; i < 2*R-1; i++)
      for (int j = 0; j < R; j++) h[i+j] += b2[i];

    $display("[TB] constant ones");
    doReset();
    applyStimulus(0, 6 * FRAME + 520);

    $display("[TB] constant zeros");
    doReset();
    applyStimulus(1, 6 * FRAME + 520);

    $display("[TB] ch0 alternating, ch1 high");
    doReset();
    applyStimulus(2, 6 * FRAME + 520);

    $display("[TB] reset pulse two cycles after a tick");
    doReset();
    applyStimulus(0, FRAME + 1);
    RST_i = 1'b1;
    @(posedge CK_i);
    #1;
    RST_i = 1'b0;
    applyStimulus(0, FIRST_EE + 3 * FRAME + 520);

    $display("[TB] random PDM stream");
    doReset();
    applyStimulus(3, FIRST_EE + 31 * FRAME + 520);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
